alu_stage: RTL and testbench
============================

// Module: alu_stage
// PURPOSE
//   Execute stage of the 10-phase multicycle datapath. Sits directly downstream of mux2.
//   Consumes readData1 and the operand-B select output of mux2 (saidaMux2).
//   Decodes the ALU operation from aluOp/funct3/funct7_5 and registers result, zero flag and a one-cycle valid strobe.
//   Result and zero feed the memory/write-back stages and branch logic.
// PARAMETERS
//   WIDTH        32  datapath width
//   PERIOD       10  phases per instruction; the phase counter wraps at PERIOD-1
//   DECODE_SLOT   4  phase at which the ALU control is latched; same phase at which mux2 latches operand B
//   EXEC_SLOT     5  phase at which the result is computed and registered
// PORTS
//   clock      in   1      system clock, rising edge
//   reset      in   1      asynchronous, active-low reset (0 = reset)
//   aluOp      in   2      00 load/store add; 01 branch sub; 10 R-type; 11 I-type arith
//   funct3     in   3      instruction funct3
//   funct7_5   in   1      instruction bit 30
//   readData1  in   WIDTH  operand A (register file port 1)
//   saidaMux2  in   WIDTH  operand B (mux2 output)
//   aluResult  out  WIDTH  registered ALU result
//   zero       out  1      registered flag: (result == 0)
//   aluValid   out  1      high for exactly one clock after each EXEC_SLOT edge
// BEHAVIOUR
//   - Reset (reset==0, async): cont=0, aluCtl=ADD, aluResult=0, zero=0, aluValid=0.
//     Takes effect immediately, at any phase; pending work is discarded.
//   - cont: 4-bit phase counter; after reset release it increments every edge, wrapping PERIOD-1 -> 0.
//     The top level releases this reset on the same edge that releases mux2, so both counters stay equal.
//   - Edge with cont==DECODE_SLOT: latch aluCtl = decode(aluOp, funct3, funct7_5). aluOp changes after this edge are ignored.
//   - Decode:
//       aluOp 00 -> ADD; 01 -> SUB.
//       aluOp 10 -> by funct3: 000 ADD/SUB(f7_5), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA(f7_5), 110 OR, 111 AND.
//       aluOp 11 -> same as 10, except funct3=000 is always ADD (f7_5 ignored; it is immediate bit 10).
//   - Edge with cont==EXEC_SLOT: compute from readData1, saidaMux2 and latched aluCtl.
//     Register aluResult and zero=(result==0); set aluValid=1. On the next edge aluValid returns to 0.
//   - Arithmetic: ADD/SUB modulo 2^WIDTH, no flags beyond zero.
//     Shift amount = saidaMux2[4:0]; SRA sign-fills from bit WIDTH-1.
//     SLT signed compare, SLTU unsigned compare; result is 0 or 1, zero-extended.
//   - All other phases: aluResult/zero hold; input changes have no effect.
//   - Latency: operands sampled at EXEC_SLOT edge, result visible the cycle after (cont==EXEC_SLOT+1).
// STRUCTURE
//   - Shared include alu_defs.vh: ALU control encodings (ALU_ADD..ALU_AND, 4 bits), aluOp codes, default PERIOD/slot constants.
//   - Sub-module alu_control: combinational decode of aluOp/funct3/funct7_5 -> 4-bit aluCtl.
//   - Top holds cont, the aluCtl register, the combinational ALU datapath and output registers.
// TESTING
//   1. Release reset; aluOp=00, readData1=5, saidaMux2=7 -> at cont==6: aluResult=12, zero=0, aluValid=1 for one cycle only.
//   2. aluOp=01, readData1=saidaMux2=32'h1234 -> aluResult=0, zero=1.
//   3. aluOp=10, funct3=101, readData1=32'h80000000, B=4:
//      f7_5=1 -> 32'hF8000000; f7_5=0 -> 32'h08000000. B=32'h24 uses shamt 4 -> same results.
//   4. aluOp=10, readData1=32'hFFFFFFFF, B=1: funct3=010 -> 1; funct3=011 -> 0.
//      aluOp=11, funct3=000, f7_5=1, A=3, B=2 -> 5 (ADD, not SUB).
//   5. Set aluOp=00, then switch to 01 at cont==5 (after decode edge), A=9, B=4 -> result 13.
//      Toggle operands at cont 0-3,6-9 -> outputs unchanged; aluValid exactly once per 10 cycles.
//   6. Assert reset mid-phase at cont==5 after a valid result -> aluResult=0, zero=0, aluValid=0 immediately;
//      on release cont restarts at 0 and the next valid appears at cont==6.

Source files
------------

// File: rtl/alu_stage_pkg.sv
// Shared ALU-stage types: control encodings, aluOp codes and default phase constants.
package alu_stage_pkg;

    localparam int ALUOP_W         = 2;
    localparam int CNT_W           = 4;
    localparam int DEF_WIDTH       = 32;
    localparam int DEF_PERIOD      = 10;
    localparam int DEF_DECODE_SLOT = 4;
    localparam int DEF_EXEC_SLOT   = 5;

    typedef enum logic [ALUOP_W-1:0] {
        AOP_MEM    = 2'b00,
        AOP_BRANCH = 2'b01,
        AOP_RTYPE  = 2'b10,
        AOP_ITYPE  = 2'b11
    } aluop_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_ctl_e;

endpackage

// File: rtl/alu_stage_if.sv
// Instruction/operand inputs and registered result outputs of the execute stage.
interface alu_stage_if
    import alu_stage_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic [ALUOP_W-1:0] aluOp;
    logic [2:0]         funct3;
    logic               funct7_5;
    logic [WIDTH-1:0]   readData1;
    logic [WIDTH-1:0]   saidaMux2;
    logic [WIDTH-1:0]   aluResult;
    logic               zero;
    logic               aluValid;

    modport master (
        output aluOp, funct3, funct7_5, readData1, saidaMux2,
        input  aluResult, zero, aluValid
    );

    modport slave (
        input  aluOp, funct3, funct7_5, readData1, saidaMux2,
        output aluResult, zero, aluValid
    );
endinterface

// File: rtl/alu_stage_alu_control.sv
// Combinational ALU-control decode from aluOp, funct3 and instruction bit 30.
module alu_control
    import alu_stage_pkg::*;
(
    input  logic [ALUOP_W-1:0] aluOp_i,
    input  logic [2:0]         funct3_i,
    input  logic               funct7_5_i,
    output alu_ctl_e           aluCtl_o
);

    always_comb begin
        aluCtl_o = ALU_ADD;
        case (aluOp_i)
            AOP_MEM:    aluCtl_o = ALU_ADD;
            AOP_BRANCH: aluCtl_o = ALU_SUB;
            default: begin
                case (funct3_i)
                    // For I-type, bit 30 is immediate bit 10, so ADDI never subtracts
                    3'b000: aluCtl_o = (funct7_5_i && aluOp_i == AOP_RTYPE) ? ALU_SUB : ALU_ADD;
                    3'b001: aluCtl_o = ALU_SLL;
                    3'b010: aluCtl_o = ALU_SLT;
                    3'b011: aluCtl_o = ALU_SLTU;
                    3'b100: aluCtl_o = ALU_XOR;
                    3'b101: aluCtl_o = funct7_5_i ? ALU_SRA : ALU_SRL;
                    3'b110: aluCtl_o = ALU_OR;
                    default: aluCtl_o = ALU_AND;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/alu_stage.sv
// Execute stage of the 10-phase multicycle datapath: latches ALU control at the
// decode phase, computes and registers result/zero with a one-cycle valid at the exec phase.
module alu_stage
    import alu_stage_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int PERIOD      = DEF_PERIOD,
    parameter int DECODE_SLOT = DEF_DECODE_SLOT,
    parameter int EXEC_SLOT   = DEF_EXEC_SLOT
) (
    input logic      clock,
    input logic      reset,
    alu_stage_if.slave bus
);

    logic [CNT_W-1:0] cont_q, cont_d;
    alu_ctl_e         ctl_q, ctl_d, ctl_dec;
    logic [WIDTH-1:0] result_q, result_d, alu_y;
    logic             zero_q, zero_d;
    logic             valid_q, valid_d;

    logic [WIDTH-1:0]        a, b;
    logic signed [WIDTH-1:0] a_s, b_s, sra_y;
    logic [4:0]              shamt;

    alu_control u_alu_control (
        .aluOp_i    (bus.aluOp),
        .funct3_i   (bus.funct3),
        .funct7_5_i (bus.funct7_5),
        .aluCtl_o   (ctl_dec)
    );

    assign a     = bus.readData1;
    assign b     = bus.saidaMux2;
    assign a_s   = a;
    assign b_s   = b;
    assign shamt = b[4:0];
    assign sra_y = a_s >>> shamt;

    always_comb begin
        alu_y = a + b;
        case (ctl_q)
            ALU_ADD:  alu_y = a + b;
            ALU_SUB:  alu_y = a - b;
            ALU_SLL:  alu_y = a << shamt;
            ALU_SLT:  alu_y = WIDTH'(a_s < b_s);
            ALU_SLTU: alu_y = WIDTH'(a < b);
            ALU_XOR:  alu_y = a ^ b;
            ALU_SRL:  alu_y = a >> shamt;
            ALU_SRA:  alu_y = sra_y;
            ALU_OR:   alu_y = a | b;
            ALU_AND:  alu_y = a & b;
            default:  alu_y = a + b;
        endcase
    end

    always_comb begin
        cont_d   = (cont_q == CNT_W'(PERIOD - 1)) ? '0 : cont_q + 1'b1;
        ctl_d    = ctl_q;
        result_d = result_q;
        zero_d   = zero_q;
        valid_d  = 1'b0;
        if (cont_q == CNT_W'(DECODE_SLOT)) begin
            ctl_d = ctl_dec;
        end
        if (cont_q == CNT_W'(EXEC_SLOT)) begin
            result_d = alu_y;
            zero_d   = (alu_y == '0);
            valid_d  = 1'b1;
        end
    end

    // Phase boundary: every state element advances on the clock edge
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cont_q   <= '0;
            ctl_q    <= ALU_ADD;
            result_q <= '0;
            zero_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            cont_q   <= cont_d;
            ctl_q    <= ctl_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.aluResult = result_q;
    assign bus.zero      = zero_q;
    assign bus.aluValid  = valid_q;

endmodule

// File: tb/tb_alu_stage.sv
// Randomized self-checking bench for alu_stage against a phase-level reference model.
module tb_alu_stage;

    logic clock;
    logic reset;
    int   n_total;
    int   n_fail;
    int   phase;
    logic [31:0] hold_res;
    logic        hold_zero;

    alu_stage_if #(.WIDTH(32)) bus ();

    alu_stage #(.WIDTH(32), .PERIOD(10), .DECODE_SLOT(4), .EXEC_SLOT(5)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: instruction semantics straight from the ISA rules.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [2:0] f3,
                                          input logic f7, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        logic [31:0] fill;
        sh = b % 32;
        if (op == 2'b00) return a + b;
        if (op == 2'b01) return a - b;
        case (f3)
            3'd0: return (op == 2'b10 && f7) ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: begin
                fill = (f7 && a[31]) ? ~(32'hFFFF_FFFF >> sh) : 32'd0;
                return (a >> sh) | fill;
            end
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    task automatic step();
        @(posedge clock);
        phase = (phase == 9) ? 0 : phase + 1;
        #1;
    endtask

    task automatic drive_random();
        bus.aluOp     = 2'($urandom_range(0, 3));
        bus.funct3    = 3'($urandom_range(0, 7));
        bus.funct7_5  = 1'($urandom_range(0, 1));
        bus.readData1 = $urandom;
        bus.saidaMux2 = $urandom;
    endtask

    task automatic check_idle();
        check("valid_idle", {31'd0, bus.aluValid}, 32'd0);
        check("result_hold", bus.aluResult, hold_res);
        check("zero_hold", {31'd0, bus.zero}, {31'd0, hold_zero});
    endtask

    task automatic run_instr(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                             input logic [31:0] a, input logic [31:0] b,
                             input bit late_en, input logic [1:0] late_op);
        logic [31:0] exp;
        int guard;
        guard = 0;
        while (phase != 4 && guard < 20) begin
            drive_random();
            step();
            check_idle();
            guard++;
        end
        if (phase != 4) check("phase_align", 32'(phase), 32'd4);
        bus.aluOp = op; bus.funct3 = f3; bus.funct7_5 = f7;
        bus.readData1 = a; bus.saidaMux2 = b;
        step();
        check_idle();
        // Control changes after the decode edge must be ignored; operands stay put for exec.
        if (late_en) bus.aluOp = late_op;
        else bus.aluOp = 2'($urandom_range(0, 3));
        bus.funct3   = 3'($urandom_range(0, 7));
        bus.funct7_5 = 1'($urandom_range(0, 1));
        step();
        exp = model(op, f3, f7, a, b);
        check("result", bus.aluResult, exp);
        check("zero", {31'd0, bus.zero}, {31'd0, exp == 32'd0});
        check("valid", {31'd0, bus.aluValid}, 32'd1);
        hold_res  = exp;
        hold_zero = (exp == 32'd0);
        drive_random();
        step();
        check_idle();
    endtask

    initial begin
        n_total = 0; n_fail = 0; phase = 0;
        hold_res = '0; hold_zero = 1'b0;
        reset = 1'b0;
        drive_random();
        #1;
        check("rst_result", bus.aluResult, 32'd0);
        check("rst_zero", {31'd0, bus.zero}, 32'd0);
        check("rst_valid", {31'd0, bus.aluValid}, 32'd0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        phase = 0;

        run_instr(2'b00, 3'd0, 1'b0, 32'd5, 32'd7, 1'b0, 2'b00);
        run_instr(2'b01, 3'd0, 1'b0, 32'h1234, 32'h1234, 1'b0, 2'b00);
        run_instr(2'b10, 3'd5, 1'b1, 32'h8000_0000, 32'd4, 1'b0, 2'b00);
        run_instr(2'b10, 3'd5, 1'b0, 32'h8000_0000, 32'd4, 1'b0, 2'b00);
        run_instr(2'b10, 3'd5, 1'b1, 32'h8000_0000, 32'h24, 1'b0, 2'b00);
        run_instr(2'b10, 3'd5, 1'b0, 32'h8000_0000, 32'h24, 1'b0, 2'b00);
        run_instr(2'b10, 3'd2, 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, 2'b00);
        run_instr(2'b10, 3'd3, 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, 2'b00);
        run_instr(2'b11, 3'd0, 1'b1, 32'd3, 32'd2, 1'b0, 2'b00);
        run_instr(2'b10, 3'd0, 1'b1, 32'd3, 32'd2, 1'b0, 2'b00);
        run_instr(2'b00, 3'd0, 1'b0, 32'd9, 32'd4, 1'b1, 2'b01);

        for (int i = 0; i < 120; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? ra : $urandom;
            run_instr(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                      ra, rb, 1'b0, 2'b00);
        end

        // Asynchronous reset in the middle of an instruction, after a valid result exists.
        run_instr(2'b00, 3'd0, 1'b0, 32'd100, 32'd23, 1'b0, 2'b00);
        while (phase != 5) begin
            drive_random();
            step();
        end
        reset = 1'b0;
        #1;
        check("midrst_result", bus.aluResult, 32'd0);
        check("midrst_zero", {31'd0, bus.zero}, 32'd0);
        check("midrst_valid", {31'd0, bus.aluValid}, 32'd0);
        hold_res = '0; hold_zero = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        phase = 0;
        run_instr(2'b10, 3'd6, 1'b0, 32'h00F0_0F00, 32'h0000_F00F, 1'b0, 2'b00);
        for (int i = 0; i < 20; i++) begin
            run_instr(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                      $urandom, $urandom, 1'b0, 2'b00);
        end

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end

endmodule
